seg_scan_ctrl: RTL
==================

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 SHALL have parameter N_DIGITS, default 8: number of multiplexed seven-segment digits, legal range 2..8.
REQ-002 SHALL have parameter TICK_DIV, default 100000: clk cycles per digit dwell, legal range >= 1.
REQ-003 SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 SHALL have port data  input  4*N_DIGITS  hex value per digit; nibble j (data[4j+3:4j]) belongs to digit position j.
REQ-006 SHALL have port dp  input  N_DIGITS  decimal point request per position, 1 = lit.
REQ-007 SHALL have port en_mask  input  N_DIGITS  per-position enable, 0 = position blanked.
REQ-008 SHALL have port an_n  output  N_DIGITS  anode select, active low, at most one bit low.
REQ-009 SHALL have port seg_n  output  7  segments {g,f,e,d,c,b,a}, active low.
REQ-010 SHALL have port dp_n  output  1  decimal point, active low.
REQ-011 SHALL have port frame_done  output  1  one-cycle pulse marking completion of a full scan frame.

Function
REQ-012 SHALL hold a dwell counter 0..TICK_DIV-1; tick is asserted in the cycle the counter equals TICK_DIV-1, and the counter then wraps to 0.
REQ-013 SHALL hold a scan pointer that starts at position N_DIGITS-1 and, on each tick, decrements, wrapping from 0 back to N_DIGITS-1.
REQ-014 SHALL drive an_n from a register: the bit at the current pointer position is 0 and all others are 1; when en_mask bit is 0 for that position, all bits SHALL be 1.
REQ-015 SHALL drive seg_n from a registered hex decode of the current nibble: 0-9 and A,b,C,d,E,F glyphs, with segment active = 0.
REQ-016 SHALL drive dp_n = ~dp bit of the current position, forced to 1 when the position is blanked.
REQ-017 SHALL snapshot data, dp and en_mask into shadow registers in the cycle the pointer wraps from 0 to N_DIGITS-1, and after reset release; all display outputs SHALL use only the shadow copies, so no frame mixes two input values.
REQ-018 SHALL assert frame_done for exactly one cycle, coincident with the snapshot cycle of REQ-017 (excluding the post-reset load).
REQ-019 SHALL update an_n, seg_n and dp_n one cycle after the pointer changes (registered outputs), so all three change in the same cycle.
REQ-020 With TICK_DIV=1, SHALL advance the pointer every cycle and assert frame_done every N_DIGITS cycles.
REQ-021 With en_mask all zero, SHALL hold an_n all ones while the scan and frame_done continue normally.
REQ-022 Input changes mid-frame SHALL take effect only from the next frame.

Reset
REQ-023 While rst=1: an_n all 1, seg_n 7'h7F, dp_n 1, frame_done 0, dwell counter 0, pointer N_DIGITS-1, shadow registers 0.
REQ-024 Reset asserted mid-frame SHALL abort the frame with no frame_done pulse; the first cycle after release SHALL load the shadows; the first lit digit SHALL appear one cycle later at position N_DIGITS-1.

Configuration
REQ-025 Macro SEG_LZ_SUPPRESS_EN: when defined, a position whose shadow nibble is 0 and whose positions above it (j+1..N_DIGITS-1) are also all 0 SHALL be blanked as in REQ-014; position 0 SHALL never be suppressed; dp_n still follows REQ-016 for unsuppressed positions and is 1 for suppressed ones.
REQ-026 Without SEG_LZ_SUPPRESS_EN, every enabled position SHALL display its nibble, including leading zeros.

Verification (N_DIGITS=4, TICK_DIV=4 unless stated)
REQ-027 Reset, then data=16'h12AF, en_mask=4'hF, dp=0 -> an_n cycles 0111,1011,1101,1110 at 4-cycle dwell; seg_n shows 1,2,A,F glyphs; dp_n=1 throughout.
REQ-028 Change data to 16'h0000 mid-frame -> the current frame completes with 12AF; the next frame shows 0000; the change coincides with the frame_done pulse.
REQ-029 en_mask=4'b1010, dp=4'b0010 -> an_n all 1 during dwell on positions 2 and 0; position 1 shows dp_n=0.
REQ-030 TICK_DIV=1 -> pointer advances every cycle; frame_done pulses every 4 cycles.
REQ-031 With SEG_LZ_SUPPRESS_EN, data=16'h0050 -> positions 3 and 2 blank, positions 1 and 0 show 5 and 0; data=16'h0000 -> only position 0 lit, showing 0.
REQ-032 Assert rst for 1 cycle during dwell on position 1 -> outputs match REQ-023 immediately, no frame_done pulse, and the scan restarts at position 3 per REQ-024.

Source files
------------

// File: rtl/seg_scan_ctrl_if.sv
// Display bundle for seg_scan_ctrl: per-digit inputs from the producer, multiplexed drive outputs.
// master = producer/consumer side, slave = scan controller.
interface seg_scan_ctrl_if #(
    parameter int unsigned N_DIGITS = 8
);
    logic [4*N_DIGITS-1:0] data;
    logic [N_DIGITS-1:0]   dp;
    logic [N_DIGITS-1:0]   en_mask;
    logic [N_DIGITS-1:0]   an_n;
    logic [6:0]            seg_n;
    logic                  dp_n;
    logic                  frame_done;

    modport master (
        output data, dp, en_mask,
        input  an_n, seg_n, dp_n, frame_done
    );

    modport slave (
        input  data, dp, en_mask,
        output an_n, seg_n, dp_n, frame_done
    );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller with frame-coherent shadow registers.
// Optional macro SEG_LZ_SUPPRESS_EN blanks leading-zero positions (position 0 always shown).
module seg_scan_ctrl #(
    parameter int unsigned N_DIGITS = 8,
    parameter int unsigned TICK_DIV = 100000
) (
    input logic             clk,
    input logic             rst,
    seg_scan_ctrl_if.slave  bus_io
);
    localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned PtrW = $clog2(N_DIGITS);
    localparam logic [CntW-1:0] CntMax = CntW'(TICK_DIV - 1);
    localparam logic [PtrW-1:0] PtrTop = PtrW'(N_DIGITS - 1);

    typedef enum logic [0:0] {StLoad, StScan} state_e;

    state_e                state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [PtrW-1:0]       ptr_q, ptr_d;
    logic [4*N_DIGITS-1:0] data_sh_q, data_sh_d;
    logic [N_DIGITS-1:0]   dp_sh_q, dp_sh_d;
    logic [N_DIGITS-1:0]   en_sh_q, en_sh_d;
    logic [N_DIGITS-1:0]   an_n_q, an_n_d;
    logic [6:0]            seg_n_q, seg_n_d;
    logic                  dp_n_q, dp_n_d;

    logic       tick, wrap, snap, lit, en_cur, dp_cur;
    logic [3:0] nib;
`ifdef SEG_LZ_SUPPRESS_EN
    logic [N_DIGITS-1:0] lz;
    logic                lz_run;
`endif

    function automatic logic [6:0] hex2seg_n(input logic [3:0] h);
        logic [6:0] s;
        unique case (h)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            4'hF: s = 7'h0E;
        endcase
        return s;
    endfunction

    // The dwell counter is held during the post-reset load so the first digit gets a full dwell.
    always_comb begin
        state_d = StScan;
        tick    = (state_q == StScan) && (cnt_q == CntMax);
        wrap    = tick && (ptr_q == '0);
        snap    = wrap || (state_q == StLoad);
        cnt_d   = cnt_q;
        if (state_q == StScan) begin
            cnt_d = tick ? '0 : cnt_q + CntW'(1);
        end
        ptr_d = ptr_q;
        if (tick) begin
            ptr_d = (ptr_q == '0) ? PtrTop : ptr_q - PtrW'(1);
        end
        data_sh_d = snap ? bus_io.data    : data_sh_q;
        dp_sh_d   = snap ? bus_io.dp      : dp_sh_q;
        en_sh_d   = snap ? bus_io.en_mask : en_sh_q;
    end

    always_comb begin
        nib    = 4'h0;
        en_cur = 1'b0;
        dp_cur = 1'b0;
        for (int j = 0; j < N_DIGITS; j++) begin
            if (ptr_q == PtrW'(j)) begin
                nib    = data_sh_q[4*j +: 4];
                en_cur = en_sh_q[j];
                dp_cur = dp_sh_q[j];
            end
        end
`ifdef SEG_LZ_SUPPRESS_EN
        lz     = '0;
        lz_run = 1'b1;
        for (int j = int'(N_DIGITS) - 1; j >= 0; j--) begin
            lz_run = lz_run && (data_sh_q[4*j +: 4] == 4'h0);
            lz[j]  = lz_run && (j != 0);
        end
        lit = en_cur;
        for (int j = 0; j < N_DIGITS; j++) begin
            if (ptr_q == PtrW'(j) && lz[j]) begin
                lit = 1'b0;
            end
        end
`else
        lit = en_cur;
`endif
        for (int j = 0; j < N_DIGITS; j++) begin
            an_n_d[j] = !(lit && (ptr_q == PtrW'(j)));
        end
        seg_n_d = lit ? hex2seg_n(nib) : 7'h7F;
        dp_n_d  = !(lit && dp_cur);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StLoad;
            cnt_q     <= '0;
            ptr_q     <= PtrTop;
            data_sh_q <= '0;
            dp_sh_q   <= '0;
            en_sh_q   <= '0;
            an_n_q    <= '1;
            seg_n_q   <= 7'h7F;
            dp_n_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ptr_q     <= ptr_d;
            data_sh_q <= data_sh_d;
            dp_sh_q   <= dp_sh_d;
            en_sh_q   <= en_sh_d;
            an_n_q    <= an_n_d;
            seg_n_q   <= seg_n_d;
            dp_n_q    <= dp_n_d;
        end
    end

    assign bus_io.an_n       = an_n_q;
    assign bus_io.seg_n      = seg_n_q;
    assign bus_io.dp_n       = dp_n_q;
    // Gated by rst so a reset landing on the wrap cycle aborts the frame without a pulse.
    assign bus_io.frame_done = wrap && !rst;
endmodule
